dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU memory stage and a loader/debug port.
//  Sits between the memory stage and the data memory instance, and drives the memory's W_EN/ADDR/D_IN.
//  CPU has default priority. A starvation counter forces a loader slot. A lock mode gives the loader
//  bounded bursts. CPU sees a combinational stall whenever it loses the slot.
// PARAMETERS
//  AW         10  memory word-address width (matches data memory ADDR)
//  DW         32  data width
//  STARVE_MAX 4   CPU-won contended cycles before a loader slot is forced (>=1)
//  MAX_LOCK   8   max consecutive loader beats in lock mode before a forced release (>=1)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  cpu_req    in   1   CPU access request (memory stage MemRead|MemWrite)
//  cpu_we     in   1   CPU write enable (MemWrite)
//  cpu_addr   in   AW  CPU word address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  CPU read data (combinational, = mem_dout)
//  cpu_stall  out  1   CPU lost this cycle's slot; hold the pipeline
//  ldr_req    in   1   loader request; held until ldr_ack
//  ldr_we     in   1   loader write enable
//  ldr_lock   in   1   keep ownership after this beat
//  ldr_addr   in   AW  loader word address
//  ldr_wdata  in   DW  loader write data
//  ldr_ack    out  1   loader beat performed this cycle
//  ldr_rdata  out  DW  registered loader read data
//  ldr_rvalid out  1   ldr_rdata valid (one cycle after the acked read)
//  mem_we     out  1   to data memory W_EN
//  mem_addr   out  AW  to data memory ADDR
//  mem_din    out  DW  to data memory D_IN
//  mem_dout   in   DW  from data memory D_OUT (asynchronous read)
// BEHAVIOUR
//  Memory model: D_OUT follows ADDR in the same cycle. A write commits at the clk edge when W_EN=1.
//  One access per cycle. gnt_cpu and gnt_ldr are combinational from state and requests, and are
//  mutually exclusive.
//  Mux: gnt_ldr -> mem_* from ldr_*, mem_we=ldr_we.
//       Otherwise -> mem_addr/mem_din from cpu_*, mem_we=cpu_we&gnt_cpu.
//  cpu_stall = cpu_req & ~gnt_cpu.  ldr_ack = gnt_ldr.
//  States (2-bit):
//   PRIO: gnt_cpu=cpu_req; gnt_ldr=ldr_req&~cpu_req.
//     If cpu_req&ldr_req: starve_cnt++.
//       When starve_cnt reaches STARVE_MAX-1 on such a cycle -> FORCE, starve_cnt<=0.
//     If gnt_ldr: starve_cnt<=0.
//     If gnt_ldr&ldr_lock -> LOCK, lock_cnt<=1.
//   FORCE: gnt_ldr=ldr_req; gnt_cpu=0.
//     If ldr_req&ldr_lock -> LOCK, lock_cnt<=1.
//     Otherwise -> PRIO (this includes ldr_req dropped: no access occurs).
//   LOCK: gnt_ldr=ldr_req; gnt_cpu=0.
//     If ~ldr_req, or ~ldr_lock on the granted beat, or lock_cnt==MAX_LOCK -> PRIO.
//     Otherwise lock_cnt++.
//     With lock_cnt==MAX_LOCK, no loader grant occurs; CPU is guaranteed that cycle.
//  Counter widths: starve_cnt $clog2(STARVE_MAX+1); lock_cnt $clog2(MAX_LOCK+1). Neither wraps.
//  Read return:
//   - On an edge with gnt_ldr&~ldr_we: ldr_rdata<=mem_dout, ldr_rvalid<=1.
//   - Otherwise ldr_rvalid<=0 and ldr_rdata holds.
//  Same-cycle CPU write then loader read of the same address: the loader sees the new data the
//  cycle after the write.
//  Reset (rst_n=0, asynchronous):
//   - state=PRIO, starve_cnt=0, lock_cnt=0, ldr_rvalid=0, ldr_rdata=0.
//   - While rst_n=0: mem_we=0, ldr_ack=0, cpu_stall=0.
//   - Reset mid-LOCK/FORCE aborts the beat and suppresses that cycle's write.
// TESTING
//  Reset: rst_n=0 with cpu_req=ldr_req=ldr_we=1 -> mem_we=0, ldr_ack=0, ldr_rvalid=0.
//    Release -> state PRIO.
//  Starvation (STARVE_MAX=4): cpu_req and ldr_req held high ->
//    CPU granted 4 cycles, then ldr_ack=1 and cpu_stall=1 for 1 cycle, then repeat.
//  Loader write/read: ldr write 0xDEADBEEF to addr 0x03A with CPU idle -> ldr_ack=1, mem_we=1 same cycle.
//    Then ldr read of 0x03A -> ldr_rvalid=1 next cycle, ldr_rdata=0xDEADBEEF.
//    CPU read of 0x03A -> cpu_rdata=0xDEADBEEF.
//  Lock bound (MAX_LOCK=8): ldr_lock=1 for 12 beats with cpu_req=1 ->
//    8 consecutive acks with cpu_stall=1, then 1 CPU cycle with ldr_ack=0, then PRIO arbitration resumes.
//  Early release: ldr_lock dropped on beat 3 -> ack on beat 3, next cycle CPU granted, lock_cnt unused.
//  Reset mid-lock: rst_n low on beat 5 of a write burst ->
//    mem_we drops immediately, no write to that address, ldr_rvalid=0, state PRIO.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU memory
// stage and a loader/debug port. The CPU wins by default. A starvation counter
// forces a loader slot after STARVE_MAX contended CPU wins. Lock mode lets the
// loader keep the port for at most MAX_LOCK consecutive beats.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU memory-stage access
//   cpu_rdata                     CPU read data (combinational, = mem_dout)
//   cpu_stall                     CPU lost the slot this cycle (combinational)
//   ldr_req/we/lock/addr/wdata    loader access; ldr_lock keeps ownership
//   ldr_ack                       loader beat performed this cycle (combinational)
//   ldr_rdata, ldr_rvalid         registered loader read return
//   mem_we/addr/din               to the data memory
//   mem_dout                      from the data memory (asynchronous read)
module dmem_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MAX_LOCK   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic          ldr_lock,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned LW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    PRIO  = 2'd0,
    FORCE = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lock_cnt;
  logic          gnt_cpu;
  logic          gnt_ldr;
  logic          lock_full;
  logic          contended;

  assign lock_full = (lock_cnt == LW'(MAX_LOCK));
  assign contended = cpu_req & ldr_req;

  // Grant decode; both grants are held low while in reset so nothing is written.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ldr = 1'b0;
    if (rst_n) begin
      case (state)
        PRIO: begin
          gnt_cpu = cpu_req;
          gnt_ldr = ldr_req & ~cpu_req;
        end
        FORCE: gnt_ldr = ldr_req;
        LOCK: begin
          // Exhausted burst: loader is refused and the CPU gets this slot.
          if (lock_full) gnt_cpu = cpu_req;
          else           gnt_ldr = ldr_req;
        end
        default: begin
          gnt_cpu = 1'b0;
          gnt_ldr = 1'b0;
        end
      endcase
    end
  end

  // Memory port mux and handshake outputs.
  assign mem_we    = gnt_ldr ? ldr_we    : (cpu_we & gnt_cpu);
  assign mem_addr  = gnt_ldr ? ldr_addr  : cpu_addr;
  assign mem_din   = gnt_ldr ? ldr_wdata : cpu_wdata;
  assign cpu_rdata = mem_dout;
  assign cpu_stall = rst_n & cpu_req & ~gnt_cpu;
  assign ldr_ack   = gnt_ldr;

  // Arbitration state, counters and loader read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIO;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      ldr_rvalid <= 1'b0;
      ldr_rdata  <= '0;
    end else begin
      ldr_rvalid <= gnt_ldr & ~ldr_we;
      if (gnt_ldr & ~ldr_we) ldr_rdata <= mem_dout;

      case (state)
        PRIO: begin
          if (contended) begin
            if (starve_cnt == SW'(STARVE_MAX - 1)) begin
              state      <= FORCE;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end
          if (gnt_ldr) begin
            starve_cnt <= '0;
            if (ldr_lock) begin
              state    <= LOCK;
              lock_cnt <= LW'(1);
            end
          end
        end
        FORCE: begin
          if (ldr_req & ldr_lock) begin
            state    <= LOCK;
            lock_cnt <= LW'(1);
          end else begin
            state <= PRIO;
          end
        end
        LOCK: begin
          if (~ldr_req | ~ldr_lock | lock_full) begin
            state    <= PRIO;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: state <= PRIO;
      endcase
    end
  end

endmodule
